// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back / write-allocate, blocking data cache.
// A hit completes in the same cycle. A miss stalls the CPU, optionally writes
// back a dirty victim, refills the whole line from backing memory, and then
// retries in IDLE so the request completes as a hit.
// Optional feature macro: DCACHE_STATS_EN adds saturating hit/miss counters.
module dcache_direct_mapped #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4,
  localparam int IDX_W     = $clog2(NUM_SETS),
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int LINE_BITS = 32 * LINE_WORDS,
  localparam int TAG_W     = 32 - IDX_W - OFF_W - 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req_valid,
  input  logic                 cpu_req_write,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_din,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_dout,
  output logic                 mem_req_valid,
  output logic                 mem_req_write,
  output logic [31:0]          mem_req_addr,
  output logic [LINE_BITS-1:0] mem_req_data,
  input  logic                 mem_req_ready,
  input  logic                 mem_resp_valid,
  input  logic [LINE_BITS-1:0] mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  typedef enum logic [1:0] {IDLE, WB_REQ, RD_REQ, RD_WAIT} state_t;

  state_t state, state_nx;

  // line storage; data/tag are left uninitialised, valid/dirty guard them
  logic [LINE_WORDS-1:0][31:0] data_mem [NUM_SETS];
  logic [TAG_W-1:0]            tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0]         valid_q;
  logic [NUM_SETS-1:0]         dirty_q;

  // address of the request being serviced by a miss
  logic [TAG_W-1:0] miss_tag;
  logic [IDX_W-1:0] miss_idx;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_word;
  logic             req_live, line_hit, hit, miss, victim_dirty;
  logic             wb_acc, rd_acc, refill;
  logic             unused_addr_bits;

  assign req_tag          = cpu_addr[31 -: TAG_W];
  assign req_idx          = cpu_addr[IDX_W+OFF_W+1 : OFF_W+2];
  assign req_word         = cpu_addr[OFF_W+1 : 2];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // a request is never serviced while reset is held
  assign req_live     = cpu_req_valid && !reset;
  assign line_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign hit          = (state == IDLE) && req_live && line_hit;
  assign miss         = (state == IDLE) && req_live && !line_hit;
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign wb_acc       = (state == WB_REQ) && mem_req_ready;
  assign rd_acc       = (state == RD_REQ) && mem_req_ready;
  assign refill       = (state == RD_WAIT) && mem_resp_valid;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (miss) state_nx = victim_dirty ? WB_REQ : RD_REQ;
      WB_REQ:  if (wb_acc) state_nx = RD_REQ;
      RD_REQ:  if (rd_acc) state_nx = RD_WAIT;
      RD_WAIT: if (refill) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: memory request fields depend only on registered state, so they
  // hold steady while the memory stalls the handshake
  always_comb begin
    cpu_ready     = hit;
    cpu_dout      = '0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    if (hit && !cpu_req_write) cpu_dout = data_mem[req_idx][req_word];
    case (state)
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_mem[miss_idx], miss_idx, {(OFF_W+2){1'b0}}};
        mem_req_data  = data_mem[miss_idx];
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {miss_tag, miss_idx, {(OFF_W+2){1'b0}}};
      end
      default: ;
    endcase
  end

  // line status bits and miss address capture
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      dirty_q  <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else begin
      if (miss) begin
        miss_tag <= req_tag;
        miss_idx <= req_idx;
      end
      if (hit && cpu_req_write) dirty_q[req_idx] <= 1'b1;
      if (wb_acc) dirty_q[miss_idx] <= 1'b0;
      if (refill) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // data/tag arrays: store hits write one word, refills write the whole line
  always_ff @(posedge clk) begin
    if (hit && cpu_req_write) data_mem[req_idx][req_word] <= cpu_din;
    if (refill) begin
      data_mem[miss_idx] <= mem_resp_data;
      tag_mem[miss_idx]  <= miss_tag;
    end
  end

`ifdef DCACHE_STATS_EN
  // saturating counters; a retried request after refill counts as a hit
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
      if (miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
